// File: rtl/bcd_sseg_scanner_if.sv
// Bus bundle for bcd_sseg_scanner: BCD update strobe in, multiplexed display drive out.
// load is a single-cycle strobe with no ready: the scanner always accepts digits_in/unit_f
// in the cycle load is high, and the last accepted value before a frame boundary is committed.
interface bcd_sseg_scanner_if;
  logic [11:0] digits_in;
  logic        unit_f;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_sync;
  logic [1:0]  scan_idx;

  modport master (
    output digits_in, unit_f, load,
    input  an, seg, dp, frame_sync, scan_idx
  );

  modport slave (
    input  digits_in, unit_f, load,
    output an, seg, dp, frame_sync, scan_idx
  );
endinterface

// File: rtl/bcd_sseg_scanner.sv
// Four-position common-anode scanner: ones, tens, hundreds, then the C/F unit symbol.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_sseg_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input logic             clk,
  input logic             reset,
  bcd_sseg_scanner_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;

  typedef enum logic [1:0] {
    SCAN_ONES = 2'd0,
    SCAN_TENS = 2'd1,
    SCAN_HUND = 2'd2,
    SCAN_UNIT = 2'd3
  } scan_t;

  logic [CNT_W-1:0] cnt;
  scan_t            idx;
  logic             tick;
  logic             boundary;

  logic [11:0]      pend_digits;
  logic             pend_unit;
  logic             pend_flag;
  logic [11:0]      disp_digits;
  logic             disp_unit;

  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             fs_q;

  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  logic             blank_hund;
  logic             blank_tens;

  function automatic logic [6:0] bcd_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = GLYPH_DASH;
    endcase
    return g;
  endfunction

  assign tick     = (cnt == CNT_MAX);
  assign boundary = tick && (idx == SCAN_UNIT);

`ifdef LEADING_ZERO_BLANK_EN
  // Tens only blanks when hundreds is also zero, so "105" keeps its inner zero.
  assign blank_hund = (disp_digits[11:8] == 4'd0);
  assign blank_tens = blank_hund && (disp_digits[7:4] == 4'd0);
`else
  assign blank_hund = 1'b0;
  assign blank_tens = 1'b0;
`endif

  always_comb begin
    seg_next = GLYPH_BLANK;
    an_next  = ~(4'b0001 << idx);
    case (idx)
      SCAN_ONES: seg_next = bcd_glyph(disp_digits[3:0]);
      SCAN_TENS: seg_next = blank_tens ? GLYPH_BLANK : bcd_glyph(disp_digits[7:4]);
      SCAN_HUND: seg_next = blank_hund ? GLYPH_BLANK : bcd_glyph(disp_digits[11:8]);
      SCAN_UNIT: seg_next = disp_unit ? GLYPH_F : GLYPH_C;
      default:   seg_next = GLYPH_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= SCAN_ONES;
      pend_digits <= '0;
      pend_unit   <= 1'b0;
      pend_flag   <= 1'b0;
      disp_digits <= '0;
      disp_unit   <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= GLYPH_BLANK;
      fs_q        <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= scan_t'(idx + 2'd1);
      end

      // Display commits the previously flagged value; a load on this same cycle
      // lands in pending and waits for the next boundary.
      if (boundary && pend_flag) begin
        disp_digits <= pend_digits;
        disp_unit   <= pend_unit;
      end
      pend_flag <= bus.load | (pend_flag & ~boundary);
      if (bus.load) begin
        pend_digits <= bus.digits_in;
        pend_unit   <= bus.unit_f;
      end

      an_q  <= an_next;
      seg_q <= seg_next;
      fs_q  <= boundary;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = 1'b1;
  assign bus.frame_sync = fs_q;
  assign bus.scan_idx   = idx;

endmodule

// File: doc/bcd_sseg_scanner.md
# bcd_sseg_scanner

Time-multiplexed four-digit seven-segment driver that sits directly downstream of the binary-to-BCD digit separator in the temperature-conversion datapath. It accepts three packed BCD digits plus a Celsius/Fahrenheit flag and scans them, together with a unit symbol, onto a common-anode display. Updates are double-buffered and commit only at a frame boundary, so a digit change never tears mid-scan.

## Interface
Parameters:
- REFRESH_DIV, default 100000: clock cycles each digit is lit. Legal range is 2 or more; 100000 gives 1 kHz per digit at 100 MHz.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- digits_in  in  12  packed BCD: [3:0] ones, [7:4] tens, [11:8] hundreds.
- unit_f  in  1  0 = Celsius ('C'), 1 = Fahrenheit ('F').
- load  in  1  single-cycle strobe; captures digits_in and unit_f into the pending buffer.
- an  out  4  digit anodes, active-low; an[0] is the ones digit and an[3] is the unit symbol.
- seg  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low; tied to 1 (off).
- frame_sync  out  1  one-cycle pulse when the scan wraps from index 3 to 0.

## Operation
- **Tick counter:** cnt runs 0..REFRESH_DIV-1 and wraps. tick = (cnt == REFRESH_DIV-1).
- **Scan index:** idx is 2 bits and advances 0→1→2→3→0 on each tick.
- **Frame boundary:** tick && idx == 3.
- **Buffers:**
  - pending holds {digits, unit} plus pend_flag.
  - display holds {digits, unit}.
- **On a frame boundary:** if pend_flag is set, display <= pending.
- **Load rule (every cycle):** pend_flag <= load | (pend_flag & ~boundary). If load is high, pending <= inputs.
- **Load on the boundary cycle:** display takes the old pending, if flagged. The new value lands in pending with pend_flag=1.
- **Back-to-back loads:** the last load before a boundary wins.
- **Decode for each idx:**
  - 0: ones digit.
  - 1: tens digit.
  - 2: hundreds digit.
  - 3: 'C' = 1000110 or 'F' = 0001110.
- **Digit glyphs:**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- **Invalid BCD code (10..15):** shows a dash, 0111111.
- **Blank glyph:** 1111111.
- **Anode driving:** an = ~(1 << idx_q), where idx_q is the registered index.

## Timing
- an and seg are registered: they reflect idx one cycle after idx changes.
- frame_sync is registered and asserts in the cycle after the boundary cycle.
- Reset values:
  - cnt=0, idx=0, pend_flag=0.
  - pending and display digits = 0, unit=0.
  - an=1111, seg=1111111, dp=1, frame_sync=0.
- First cycle after reset release: an=1110 and seg shows '0' (display=000).
- load-to-visible latency:
  - The value appears at the first boundary after the load, plus 1 cycle for output registration.
  - Worst case is 4·REFRESH_DIV+1 cycles.
- Reset asserted mid-frame: everything returns to reset values immediately, and any pending load is discarded.
- Each digit is lit for exactly REFRESH_DIV cycles; a frame is 4·REFRESH_DIV cycles.

## Configuration
- **LEADING_ZERO_BLANK_EN defined:**
  - Hundreds is blanked when it is 0.
  - Tens is blanked when hundreds and tens are both 0.
  - Ones and the unit symbol are never blanked.
  - Blanked positions still cycle their anode, with seg=1111111.
- **Macro undefined:** all three digits are always shown, including leading zeros.

## Test plan
- Reset, then run with REFRESH_DIV=4.
  - an must sequence 1110,1101,1011,0111 with 4 cycles each.
  - seg must be '0' on the digit positions and 'C' on an[3].
  - frame_sync must pulse every 16 cycles.
- load with digits_in=12'h098 and unit_f=1 mid-frame.
  - The old value persists until the boundary.
  - The next frame shows 8, 9, hundreds, then 'F'.
  - Hundreds is '0', or blank with LEADING_ZERO_BLANK_EN.
- load 12'h007 then 12'h123 within one frame: only 1,2,3 is ever displayed.
- load 12'h045 asserted exactly on the boundary cycle:
  - Display keeps its prior value for the next frame.
  - 045 appears one frame later.
- load 12'h0A5: tens position shows the dash 0111111.
- Assert reset mid-frame with a load pending:
  - an=1111 and seg=1111111 immediately.
  - After release the display shows 000 'C'.
